// File: rtl/bcol_pkg.sv
// Shared defaults and width helper for the B-column select pipeline.
package bcol_pkg;

    localparam int DEF_DATA_W = 32'sd24;
    localparam int DEF_N_COLS = 32'sd32;
    localparam int DEF_LANES  = 32'sd32;
    localparam int DEF_GRP    = 32'sd8;

    // Ceiling log2 with a floor of one bit, so a 2-entry select still has a wire.
    function automatic int sel_width(input int n);
        int w;
        w = 32'sd1;
        while ((32'sd1 << w) < n) begin
            w = w + 32'sd1;
        end
        return w;
    endfunction

endpackage

// File: rtl/bcol_select_pipe_lane.sv
// One lane of the two-stage column mux: group pre-select, final select and sticky range error.
module bcol_lane_mux
    import bcol_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int N_COLS = DEF_N_COLS,
    parameter int GRP    = DEF_GRP,
    localparam int SEL_W = sel_width(N_COLS)
)(
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           i_s1_load,
    input  logic                           i_s2_load,
    input  logic                           i_out_xfer,
    input  logic                           i_err_clr,
    input  logic [N_COLS-1:0][DATA_W-1:0]  i_cols,
    input  logic [SEL_W-1:0]               i_sel,
    output logic [DATA_W-1:0]              o_data,
    output logic                           o_err
);

    localparam int GRP_W = sel_width(GRP);
    localparam int NGRP  = (N_COLS + GRP - 32'sd1) / GRP;
    localparam int UP_W  = (SEL_W > GRP_W) ? (SEL_W - GRP_W) : 32'sd1;
    localparam int SELX  = GRP_W + UP_W;

    logic [SELX-1:0]                  w_sel_x;
    logic [GRP_W-1:0]                 w_lo;
    logic [UP_W-1:0]                  w_up;
    logic                             w_oor;
    logic [(1<<SELX)-1:0][DATA_W-1:0] w_pad;
    logic [NGRP-1:0][DATA_W-1:0]      w_grp;
    logic [(1<<UP_W)-1:0][DATA_W-1:0] w_grp_pad;
    logic [DATA_W-1:0]                w_pick;

    logic [NGRP-1:0][DATA_W-1:0]      r_grp;
    logic [UP_W-1:0]                  r_up;
    logic                             r_oor;
    logic                             r_oor2;
    logic [DATA_W-1:0]                r_data;
    logic                             r_err;

    assign w_sel_x = SELX'(i_sel);
    assign w_lo    = w_sel_x[GRP_W-1:0];
    assign w_up    = w_sel_x[SELX-1:GRP_W];
    assign w_oor   = (32'(i_sel) >= N_COLS);

    // Pad the column list to a full power-of-two so tail entries of the last group read zero.
    for (genvar c = 0; c < (1 << SELX); c++) begin : g_pad
        if (c < N_COLS) begin : g_col
            assign w_pad[c] = i_cols[c];
        end else begin : g_zero
            assign w_pad[c] = '0;
        end
    end

    // Stage-1 group muxes: every group picks its entry with the low select bits.
    always_comb begin
        w_grp = '0;
        for (int g = 0; g < NGRP; g++) begin
            w_grp[g] = w_pad[{UP_W'(g), w_lo}];
        end
    end

    // Stage-2 final mux over the registered group results.
    always_comb begin
        w_grp_pad = '0;
        for (int g = 0; g < NGRP; g++) begin
            w_grp_pad[g] = r_grp[g];
        end
        w_pick = r_oor ? '0 : w_grp_pad[r_up];
    end

    // Stage-1 capture of group words, upper select bits and range flag.
    always_ff @(posedge clk) begin
        if (i_s1_load) begin
            r_grp <= w_grp;
            r_up  <= w_up;
            r_oor <= w_oor;
        end
    end

    // Stage-2 output register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_data <= '0;
            r_oor2 <= 1'b0;
        end else if (i_s2_load) begin
            r_data <= w_pick;
            r_oor2 <= r_oor;
        end
    end

    // Sticky error: a beat leaving with a bad select sets it, and that set beats a clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_err <= 1'b0;
        end else if (i_out_xfer && r_oor2) begin
            r_err <= 1'b1;
        end else if (i_err_clr) begin
            r_err <= 1'b0;
        end
    end

    assign o_data = r_data;
    assign o_err  = r_err;

endmodule

// File: rtl/bcol_select_pipe.sv
// Per-lane B-operand column selector with a two-stage valid/ready pipeline and broadcast mode.
module bcol_select_pipe
    import bcol_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int N_COLS = DEF_N_COLS,
    parameter int LANES  = DEF_LANES,
    parameter int GRP    = DEF_GRP,
    localparam int SEL_W = sel_width(N_COLS)
)(
    input  logic                                      clk,
    input  logic                                      reset,
    input  logic                                      in_valid,
    output logic                                      in_ready,
    input  logic [N_COLS-1:0][LANES-1:0][DATA_W-1:0]  col_data,
    input  logic [LANES-1:0][SEL_W-1:0]               sel,
    input  logic                                      bcast,
    output logic                                      out_valid,
    input  logic                                      out_ready,
    output logic [LANES-1:0][DATA_W-1:0]              out_data,
    output logic [LANES-1:0]                          sel_err,
    input  logic                                      err_clr
);

    logic                                     r_s1_valid;
    logic                                     r_out_valid;
    logic                                     w_s1_en;
    logic                                     w_s2_en;
    logic                                     w_out_xfer;
    logic [LANES-1:0][N_COLS-1:0][DATA_W-1:0] w_cols;

    assign w_s2_en    = !r_out_valid || out_ready;
    assign w_s1_en    = !r_s1_valid || w_s2_en;
    assign w_out_xfer = r_out_valid && out_ready;
    assign in_ready   = w_s1_en;
    assign out_valid  = r_out_valid;

    // Shared valid pipeline for all lanes.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1_valid  <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            if (w_s1_en) begin
                r_s1_valid <= in_valid;
            end
            if (w_s2_en) begin
                r_out_valid <= r_s1_valid;
            end
        end
    end

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        for (genvar c = 0; c < N_COLS; c++) begin : g_gather
            assign w_cols[l][c] = col_data[c][l];
        end

        bcol_lane_mux #(
            .DATA_W (DATA_W),
            .N_COLS (N_COLS),
            .GRP    (GRP)
        ) u_lane (
            .clk        (clk),
            .reset      (reset),
            .i_s1_load  (w_s1_en && in_valid),
            .i_s2_load  (w_s2_en && r_s1_valid),
            .i_out_xfer (w_out_xfer),
            .i_err_clr  (err_clr),
            .i_cols     (w_cols[l]),
            .i_sel      (bcast ? sel[0] : sel[l]),
            .o_data     (out_data[l]),
            .o_err      (sel_err[l])
        );
    end

endmodule

// File: doc/bcol_select_pipe.md
BCOL_SELECT_PIPE -- requirements
Module: bcol_select_pipe

Interface
REQ-001 Parameter DATA_W, default 24, width of one B-operand word.
REQ-002 Parameter N_COLS, default 32, number of candidate columns; range 2..64.
REQ-003 Parameter LANES, default 32, number of DSP cascade lanes.
REQ-004 Parameter GRP, default 8, stage-1 mux width; power of two, 2..N_COLS.
REQ-005 Derived constants SEL_W=clog2(N_COLS) and NGRP=ceil(N_COLS/GRP).
REQ-006 Port clk, input, 1, clock; all logic rising-edge.
REQ-007 Port reset, input, 1, synchronous, active-high reset.
REQ-008 Port in_valid, input, 1, column data and selects valid.
REQ-009 Port in_ready, output, 1, block accepts the current beat.
REQ-010 Port col_data, input, N_COLS x LANES x DATA_W, column vectors.
REQ-011 Port sel, input, LANES x SEL_W, per-lane column index.
REQ-012 Port bcast, input, 1, sampled with the beat; 1 = sel[0] drives every lane.
REQ-013 Port out_valid, output, 1, out_data valid.
REQ-014 Port out_ready, input, 1, downstream accepts out_data.
REQ-015 Port out_data, output, LANES x DATA_W, selected words.
REQ-016 Port sel_err, output, LANES, sticky out-of-range flag per lane.
REQ-017 Port err_clr, input, 1, single-cycle clear of sel_err.

Function
- REQ-018 Beat transfers on in_valid && in_ready; output transfers on out_valid && out_ready.
- REQ-019 Stage 1 registers, per lane, NGRP group-mux results (col_data[g*GRP + sel[GRP_W-1:0]]), the upper select bits, the valid bit, and the out-of-range bit.
- REQ-020 Stage 2 registers the final NGRP:1 mux using the stage-1 upper select bits; output is registered; latency is exactly 2 cycles with no backpressure.
- REQ-021 Effective select = sel[0] for all lanes when bcast=1, else sel[lane].
- REQ-022 Group entries beyond N_COLS-1 read as zero.
- REQ-023 Effective select >= N_COLS yields out_data lane = 0 and sets sel_err[lane] when that beat transfers out.
- REQ-024 Each stage advances when its valid is 0 or the next stage advances; in_ready = !s1_valid || s2 advances; full throughput, 1 beat/cycle.
- REQ-025 Under out_valid && !out_ready, out_data and out_valid hold stable, stage-1 holds, and no beat is lost or duplicated.
- REQ-026 err_clr in the same cycle as a new error: the set wins.
- REQ-027 Data registers capture only on stage enable; invalid beats do not alter sel_err.

Reset
- REQ-028 Reset clears s1_valid, out_valid, sel_err to 0 and out_data to 0; in_ready is 1 in the first cycle after reset.
- REQ-029 Reset mid-operation discards all in-flight beats; no output transfer occurs for them.

Structure
- REQ-030 Shared package bcol_pkg holds default DATA_W/N_COLS/LANES/GRP and a clog2-based SEL_W helper function.
- REQ-031 One sub-module, bcol_lane_mux, implements the two-stage mux and error bit for one lane; it is instantiated LANES times; handshake logic is shared in the top.

Verification
- REQ-032 Scenario: reset, then col_data[c][l]=c*256+l, sel[l]=l, bcast=0, out_ready=1 -> 2 cycles later out_data[l]=l*256+l, out_valid=1 for one cycle.
- REQ-033 Scenario: bcast=1, sel[0]=5, sel[others]=0 -> every lane l outputs 5*256+l.
- REQ-034 Scenario: N_COLS=20, sel[3]=25 -> out_data[3]=0, sel_err=0x8 after transfer; err_clr -> sel_err=0.
- REQ-035 Scenario: stream 10 beats back-to-back with out_ready low at cycles 4-6 -> all 10 outputs arrive in order, none duplicated, in_ready low while both stages are full.
- REQ-036 Scenario: reset asserted with 2 beats in flight -> out_valid=0 next cycle, no stale beat emitted afterward.
- REQ-037 Scenario: sel[l]=7,8,15,16,31 (group boundaries) -> correct column words at each lane.
